redmule_tile_scheduler: RTL and testbench

//  Walks the tile iteration space produced by the tiler: m-tiles (outer), k-tiles (middle), n-chunks (inner).

---
 rtl/redmule_pkg.sv | 23 ++
 rtl/redmule_tile_counter.sv | 31 +++
 rtl/redmule_tile_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_redmule_tile_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared types for the RedMulE tile scheduler
package redmule_pkg;

  localparam int unsigned TS_ADDR_W  = 32;
  localparam int unsigned TS_FLAGS_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CFG,
    ISSUE,
    DRAIN,
    DONE
  } tile_sched_state_e;

  // flags = {first_n, last_n, part_m, part_k, part_n}
  typedef struct packed {
    logic [TS_ADDR_W-1:0]  x_addr;
    logic [TS_ADDR_W-1:0]  w_addr;
    logic [TS_ADDR_W-1:0]  z_addr;
    logic [TS_FLAGS_W-1:0] flags;
  } tile_desc_t;

endpackage

// File: rtl/redmule_tile_counter.sv
// rtl/redmule_tile_counter.sv - wrap counter for one tile iteration dimension
module redmule_tile_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] max_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == max_i);
  assign wrap_o = en_i & w_last;
  assign cnt_o  = r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/redmule_tile_scheduler.sv
// rtl/redmule_tile_scheduler.sv - walks m/k/n tiles and issues X/W/Z tile descriptors
module redmule_tile_scheduler
  import redmule_pkg::*;
#(
  parameter int unsigned ADDR_W    = TS_ADDR_W,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic              cfg_valid_i,
  input  logic [ADDR_W-1:0] x_base_i,
  input  logic [ADDR_W-1:0] w_base_i,
  input  logic [ADDR_W-1:0] z_base_i,
  input  logic [CNT_W-1:0]  x_rows_iter_i,
  input  logic [CNT_W-1:0]  w_cols_iter_i,
  input  logic [CNT_W-1:0]  x_cols_iter_i,
  input  logic [ADDR_W-1:0] x_rows_offs_i,
  input  logic [ADDR_W-1:0] x_col_step_i,
  input  logic [ADDR_W-1:0] w_row_step_i,
  input  logic [ADDR_W-1:0] w_col_step_i,
  input  logic [ADDR_W-1:0] z_row_offs_i,
  input  logic [ADDR_W-1:0] z_col_step_i,
  input  logic              m_lftovr_i,
  input  logic              k_lftovr_i,
  input  logic              n_lftovr_i,
  output logic              tile_valid_o,
  input  logic              tile_ready_i,
  output logic [ADDR_W-1:0] tile_x_addr_o,
  output logic [ADDR_W-1:0] tile_w_addr_o,
  output logic [ADDR_W-1:0] tile_z_addr_o,
  output logic [4:0]        tile_flags_o,
  input  logic              store_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

  tile_sched_state_e r_state, w_state_nxt;
  logic              w_capture, w_set_err, w_cfg_zero;
  logic              r_valid, w_valid_nxt, w_acc;
  logic              r_err;
  logic [OUT_W-1:0]  r_outst, w_outst_nxt;
  logic              w_inc;

  logic [ADDR_W-1:0] r_xa, r_wa, r_za, r_x_row, r_w_col, r_z_row, r_w_base;
  logic [ADDR_W-1:0] r_x_rows_offs, r_x_col_step, r_w_row_step, r_w_col_step;
  logic [ADDR_W-1:0] r_z_row_offs, r_z_col_step;
  logic [ADDR_W-1:0] w_x_row_nxt, w_w_col_nxt, w_z_row_nxt;
  logic [CNT_W-1:0]  r_m_max, r_k_max, r_n_max;
  logic [2:0]        r_lft;

  logic [CNT_W-1:0]  w_m_cnt, w_k_cnt, w_n_cnt, w_n_inc;
  logic              w_m_wrap, w_k_wrap, w_n_wrap, w_cnt_clr;
  logic              w_m_last, w_k_last, w_n_last, w_n_last_nxt;
  tile_desc_t        w_desc;

  assign w_acc      = r_valid & tile_ready_i;
  assign w_cnt_clr  = w_capture | clear_i;
  assign w_cfg_zero = (x_rows_iter_i == '0) | (w_cols_iter_i == '0) | (x_cols_iter_i == '0);

  redmule_tile_counter #(.CNT_W(CNT_W)) u_n_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(w_cnt_clr), .en_i(w_acc),
    .max_i(r_n_max), .cnt_o(w_n_cnt), .wrap_o(w_n_wrap)
  );
  redmule_tile_counter #(.CNT_W(CNT_W)) u_k_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(w_cnt_clr), .en_i(w_n_wrap),
    .max_i(r_k_max), .cnt_o(w_k_cnt), .wrap_o(w_k_wrap)
  );
  redmule_tile_counter #(.CNT_W(CNT_W)) u_m_cnt (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(w_cnt_clr), .en_i(w_k_wrap),
    .max_i(r_m_max), .cnt_o(w_m_cnt), .wrap_o(w_m_wrap)
  );

  assign w_m_last = (w_m_cnt == r_m_max);
  assign w_k_last = (w_k_cnt == r_k_max);
  assign w_n_last = (w_n_cnt == r_n_max);
  assign w_n_inc  = w_n_cnt + 1'b1;

  // last_n of the tile that will be on the bus next cycle, so the
  // outstanding-store limit can be applied without a bubble
  assign w_n_last_nxt = !w_acc   ? w_n_last :
                        w_n_last ? (r_n_max == '0) : (w_n_inc == r_n_max);

  assign w_inc = w_acc & w_n_last;
  always_comb begin
    w_outst_nxt = r_outst;
    if (w_inc && !store_done_i) begin
      w_outst_nxt = r_outst + 1'b1;
    end else if (!w_inc && store_done_i && (r_outst != '0)) begin
      w_outst_nxt = r_outst - 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_set_err   = 1'b0;
    w_valid_nxt = 1'b0;
    unique case (r_state)
      IDLE:     if (start_i) w_state_nxt = WAIT_CFG;
      WAIT_CFG: if (cfg_valid_i) begin
        if (w_cfg_zero) begin
          w_set_err   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (w_m_wrap) begin
          w_state_nxt = DRAIN;
        end else if (r_valid && !tile_ready_i) begin
          w_valid_nxt = 1'b1;
        end else begin
          w_valid_nxt = !(w_n_last_nxt && (w_outst_nxt == OUT_W'(MAX_OUTST)));
        end
      end
      DRAIN:    if (w_outst_nxt == '0) w_state_nxt = DONE;
      DONE:     w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  assign w_x_row_nxt = r_x_row + r_x_rows_offs;
  assign w_w_col_nxt = r_w_col + r_w_col_step;
  assign w_z_row_nxt = r_z_row + r_z_row_offs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_outst <= '0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_outst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_outst <= w_outst_nxt;
      if (w_set_err) r_err <= 1'b1;
      else if (r_state == IDLE && start_i) r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      {r_xa, r_wa, r_za, r_x_row, r_w_col, r_z_row, r_w_base} <= '0;
      {r_x_rows_offs, r_x_col_step, r_w_row_step, r_w_col_step} <= '0;
      {r_z_row_offs, r_z_col_step, r_m_max, r_k_max, r_n_max, r_lft} <= '0;
    end else if (w_capture) begin
      {r_xa, r_x_row} <= {x_base_i, x_base_i};
      {r_wa, r_w_col, r_w_base} <= {w_base_i, w_base_i, w_base_i};
      {r_za, r_z_row} <= {z_base_i, z_base_i};
      r_x_rows_offs <= x_rows_offs_i;
      r_x_col_step  <= x_col_step_i;
      r_w_row_step  <= w_row_step_i;
      r_w_col_step  <= w_col_step_i;
      r_z_row_offs  <= z_row_offs_i;
      r_z_col_step  <= z_col_step_i;
      r_m_max       <= x_rows_iter_i - 1'b1;
      r_k_max       <= w_cols_iter_i - 1'b1;
      r_n_max       <= x_cols_iter_i - 1'b1;
      r_lft         <= {m_lftovr_i, k_lftovr_i, n_lftovr_i};
    end else if (w_acc) begin
      if (!w_n_wrap) begin
        r_xa <= r_xa + r_x_col_step;
        r_wa <= r_wa + r_w_row_step;
      end else if (w_k_wrap) begin
        {r_x_row, r_xa} <= {w_x_row_nxt, w_x_row_nxt};
        {r_w_col, r_wa} <= {r_w_base, r_w_base};
        {r_z_row, r_za} <= {w_z_row_nxt, w_z_row_nxt};
      end else begin
        r_xa            <= r_x_row;
        {r_w_col, r_wa} <= {w_w_col_nxt, w_w_col_nxt};
        r_za            <= r_za + r_z_col_step;
      end
    end
  end

  assign w_desc.x_addr = r_xa;
  assign w_desc.w_addr = r_wa;
  assign w_desc.z_addr = r_za;
  assign w_desc.flags  = {(w_n_cnt == '0), w_n_last, r_lft[2] & w_m_last,
                          r_lft[1] & w_k_last, r_lft[0] & w_n_last};

  assign tile_valid_o  = r_valid;
  assign tile_x_addr_o = r_valid ? w_desc.x_addr : '0;
  assign tile_w_addr_o = r_valid ? w_desc.w_addr : '0;
  assign tile_z_addr_o = r_valid ? w_desc.z_addr : '0;
  assign tile_flags_o  = r_valid ? w_desc.flags  : '0;
  assign busy_o        = (r_state == WAIT_CFG) | (r_state == ISSUE) | (r_state == DRAIN);
  assign done_o        = (r_state == DONE);
  assign err_o         = r_err;

endmodule

// File: tb/tb_redmule_tile_scheduler.sv
// tb/tb_redmule_tile_scheduler.sv - scoreboard bench for redmule_tile_scheduler
module tb_redmule_tile_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear, start, cfg_valid;
  logic [31:0] x_base, w_base, z_base;
  logic [15:0] m_iter, k_iter, n_iter;
  logic [31:0] x_rows_offs, x_col_step, w_row_step, w_col_step, z_row_offs, z_col_step;
  logic        m_lft, k_lft, n_lft;
  logic        tile_valid, tile_ready, store_done, busy, done, err;
  logic [31:0] tile_x, tile_w, tile_z;
  logic [4:0]  tile_flags;

  always #5 clk = ~clk;

  redmule_tile_scheduler #(.ADDR_W(32), .CNT_W(16), .MAX_OUTST(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start), .cfg_valid_i(cfg_valid),
    .x_base_i(x_base), .w_base_i(w_base), .z_base_i(z_base),
    .x_rows_iter_i(m_iter), .w_cols_iter_i(k_iter), .x_cols_iter_i(n_iter),
    .x_rows_offs_i(x_rows_offs), .x_col_step_i(x_col_step), .w_row_step_i(w_row_step),
    .w_col_step_i(w_col_step), .z_row_offs_i(z_row_offs), .z_col_step_i(z_col_step),
    .m_lftovr_i(m_lft), .k_lftovr_i(k_lft), .n_lftovr_i(n_lft),
    .tile_valid_o(tile_valid), .tile_ready_i(tile_ready),
    .tile_x_addr_o(tile_x), .tile_w_addr_o(tile_w), .tile_z_addr_o(tile_z),
    .tile_flags_o(tile_flags), .store_done_i(store_done),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] w;
    logic [31:0] z;
    logic [4:0]  f;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   tile_idx = 0;
  int   ready_mode = 1;   // 0: low, 1: high, 2: random
  bit   sd_rand = 1'b0;
  bit   sd_manual = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ready/store_done driver, updated just after each rising edge
  always @(posedge clk) begin
    #2;
    tile_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    store_done = sd_rand ? ($urandom_range(0, 3) == 0) : sd_manual;
  end

  // monitor: pops the scoreboard on every accepted descriptor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) done_cnt++;
      if (tile_valid && tile_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tile_valid", 64'(tile_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          tile_idx++;
          chk($sformatf("tile%0d_x", tile_idx), 64'(tile_x), 64'(e.x));
          chk($sformatf("tile%0d_w", tile_idx), 64'(tile_w), 64'(e.w));
          chk($sformatf("tile%0d_z", tile_idx), 64'(tile_z), 64'(e.z));
          chk($sformatf("tile%0d_flags", tile_idx), 64'(tile_flags), 64'(e.f));
        end
      end
    end
  end

  task automatic set_cfg(input int m, input int k, input int n, input bit lm, input bit lk, input bit ln);
    m_iter = 16'(m); k_iter = 16'(k); n_iter = 16'(n);
    m_lft = lm; k_lft = lk; n_lft = ln;
  endtask

  task automatic push_job(input int m_n, input int k_n, input int n_n);
    exp_t e;
    for (int m = 0; m < m_n; m++)
      for (int k = 0; k < k_n; k++)
        for (int n = 0; n < n_n; n++) begin
          e.x = x_base + 32'(m) * x_rows_offs + 32'(n) * x_col_step;
          e.w = w_base + 32'(k) * w_col_step + 32'(n) * w_row_step;
          e.z = z_base + 32'(m) * z_row_offs + 32'(k) * z_col_step;
          e.f = {n == 0, n == n_n - 1, m_lft && (m == m_n - 1),
                 k_lft && (k == k_n - 1), n_lft && (n == n_n - 1)};
          exp_q.push_back(e);
        end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_sd();
    @(posedge clk); #1 sd_manual = 1'b1;
    @(posedge clk); #1 sd_manual = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_done(input string name, input int prev);
    for (int i = 0; i < 3000 && done_cnt == prev; i++) @(posedge clk);
    chk(name, 64'(done_cnt - prev), 64'd1);
  endtask

  task automatic wait_q(input string name, input int sz);
    for (int i = 0; i < 300 && exp_q.size() > sz; i++) @(posedge clk);
    chk(name, 64'(exp_q.size()), 64'(sz));
  endtask

  task automatic run_job(input string name, input int m, input int k, input int n);
    int prev;
    prev = done_cnt;
    push_job(m, k, n);
    pulse_start();
    wait_done({name, "_done"}, prev);
    chk({name, "_all_tiles"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int prev;
    clear = 1'b0; start = 1'b0; cfg_valid = 1'b1;
    x_base = 32'h1000; w_base = 32'h2000; z_base = 32'h3000;
    x_rows_offs = 32'h100; x_col_step = 32'h10; w_row_step = 32'h20;
    w_col_step = 32'h400; z_row_offs = 32'h800; z_col_step = 32'h40;
    set_cfg(1, 1, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", 64'(tile_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done_err", 64'({done, err}), 64'd0);

    // single tile: flags 11000, addresses at the bases, done after store
    ready_mode = 1;
    push_job(1, 1, 1);
    pulse_start();
    wait_q("single_tile_issued", 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("single_no_done_before_store", 64'({busy, done}), 64'b10);
    pulse_sd();
    @(negedge clk);
    chk("single_done_after_store", 64'(done), 64'd1);
    @(negedge clk);
    chk("single_done_one_cycle", 64'({busy, done}), 64'd0);

    // 2x2x3 random handshake, with address wrap on the X row offset
    x_base = 32'hFFFF_FF00; x_rows_offs = 32'h0000_0200; x_col_step = 32'h8;
    w_base = 32'h4000_0000; w_row_step = 32'h44; w_col_step = 32'h1000;
    z_base = 32'h8000_0000; z_row_offs = 32'h3000; z_col_step = 32'hC;
    set_cfg(2, 2, 3, 0, 0, 0);
    ready_mode = 2; sd_rand = 1'b1;
    run_job("mkn_2x2x3", 2, 2, 3);

    // outstanding limit: N=1 makes every tile a Z store
    ready_mode = 1; sd_rand = 1'b0;
    set_cfg(2, 2, 1, 0, 0, 0);
    push_job(2, 2, 1);
    pulse_start();
    wait_q("outst_two_issued", 2);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("outst_stall_at_two", 64'({tile_valid, 6'(exp_q.size())}), 64'h02);
    pulse_sd();
    wait_q("outst_release_one", 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("outst_stall_again", 64'({tile_valid, 6'(exp_q.size())}), 64'h01);
    ready_mode = 0;
    pulse_sd();
    for (int i = 0; i < 20 && !tile_valid; i++) @(negedge clk);
    chk("outst_offer_held", 64'(tile_valid), 64'd1);
    @(posedge clk); #1 ready_mode = 1; sd_manual = 1'b1;
    @(posedge clk); #1 sd_manual = 1'b0;
    prev = done_cnt;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("outst_coincide_unchanged", 64'({busy, 8'(done_cnt - prev)}), 64'h100);
    pulse_sd();
    wait_done("outst_final_done", prev);
    chk("outst_all_tiles", 64'(exp_q.size()), 64'd0);

    // zero-size config
    set_cfg(2, 2, 0, 0, 0, 0);
    prev = done_cnt;
    pulse_start();
    wait_done("zero_done", prev);
    @(negedge clk);
    chk("zero_err_set", 64'({err, busy}), 64'b10);
    cfg_valid = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("zero_err_cleared_by_start", 64'({err, busy}), 64'b01);
    pulse_clear();
    @(negedge clk);
    chk("clear_in_wait_cfg", 64'(busy), 64'd0);
    cfg_valid = 1'b1;

    // clear mid-ISSUE, then a fresh run restarts from tile 0
    x_base = 32'h10; x_rows_offs = 32'h100; x_col_step = 32'h4;
    w_base = 32'h20; w_row_step = 32'h8; w_col_step = 32'h80;
    z_base = 32'h30; z_row_offs = 32'h200; z_col_step = 32'h2;
    set_cfg(4, 1, 2, 0, 0, 0);
    ready_mode = 0;
    pulse_start();
    for (int i = 0; i < 20 && !tile_valid; i++) @(negedge clk);
    chk("clr_valid_before", 64'(tile_valid), 64'd1);
    prev = done_cnt;
    pulse_clear();
    @(negedge clk);
    chk("clr_valid_dropped", 64'({tile_valid, busy}), 64'd0);
    repeat (5) @(posedge clk);
    chk("clr_no_done", 64'(done_cnt - prev), 64'd0);
    ready_mode = 2; sd_rand = 1'b1;
    run_job("after_clear_4x1x2", 4, 1, 2);

    // leftover flags on every dimension
    set_cfg(2, 2, 2, 1, 1, 1);
    run_job("leftover_2x2x2", 2, 2, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
